// File: rtl/cla_16_bit_rc.sv
// rtl/cla_16_bit_rc.sv - registered 16-bit adder built from four rippled 4-bit CLA slices
// Optional input register stage: CLA_INPUT_REG_EN (adds one cycle of latency).

module cla_4_bit_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4
);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum-of-products over g/p and c0; none feeds another.
    assign c1 = g[0]
              | (p[0] & c0);
    assign c2 = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c0);
    assign c3 = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
    assign c4 = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

    assign s = p ^ {c3, c2, c1, c0};
endmodule

module cla_16_bit_rc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [15:0] core_a;
    logic [15:0] core_b;
    logic        core_cin;
    logic [15:0] sum;
    logic [16:0] c;

`ifdef CLA_INPUT_REG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_a   <= 16'h0000;
            core_b   <= 16'h0000;
            core_cin <= 1'b0;
        end else begin
            core_a   <= a;
            core_b   <= b;
            core_cin <= cin;
        end
    end
`else
    assign core_a   = a;
    assign core_b   = b;
    assign core_cin = cin;
`endif

    assign c[0] = core_cin;

    // Carry ripples slice to slice; there is deliberately no group lookahead.
    for (genvar k = 0; k < 4; k++) begin : g_slice
        cla_4_bit_slice u_slice (
            .a  (core_a[4*k +: 4]),
            .b  (core_b[4*k +: 4]),
            .c0 (c[4*k]),
            .s  (sum[4*k +: 4]),
            .c4 (c[4*k+4])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s    <= 16'h0000;
            cout <= 1'b0;
        end else begin
            s    <= sum;
            cout <= c[16];
        end
    end
endmodule

// File: tb/tb_cla_16_bit_rc.sv
// tb/tb_cla_16_bit_rc.sv - directed and random self-checking bench for cla_16_bit_rc

module tb_cla_16_bit_rc;
`ifdef CLA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;

    int          checks;
    int          failures;
    logic [16:0] m_in;
    logic [16:0] m_out;

    cla_16_bit_rc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // One clock edge with the given inputs; the model tracks the expected output.
    task automatic cycle(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic tr);
        a     = ta;
        b     = tb_;
        cin   = tc;
        rst_n = tr;
        @(posedge clk);
        if (!tr) begin
            m_in  = 17'h0;
            m_out = 17'h0;
        end else begin
`ifdef CLA_INPUT_REG_EN
            m_out = m_in;
            m_in  = {1'b0, ta} + {1'b0, tb_} + {16'h0, tc};
`else
            m_out = {1'b0, ta} + {1'b0, tb_} + {16'h0, tc};
`endif
        end
        #1;
    endtask

    task automatic run(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
        for (int i = 0; i < LAT; i++) cycle(ta, tb_, tc, 1'b1);
    endtask

    task automatic check(input string tag, input logic [16:0] expv);
        checks++;
        assert ({cout, s} === expv) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, {cout, s}, expv);
        end
    endtask

    initial begin
        clk      = 1'b0;
        checks   = 0;
        failures = 0;
        m_in     = 17'h0;
        m_out    = 17'h0;
        rst_n    = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        cin      = 1'b0;

        cycle(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        check("reset_edge1", 17'h00000);
        cycle(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        check("reset_edge2", 17'h00000);
        if (LAT == 2) begin
            cycle(16'hFFFF, 16'h0001, 1'b1, 1'b1);
            check("release_zero", 17'h00000);
            cycle(16'hFFFF, 16'h0001, 1'b1, 1'b1);
        end else begin
            run(16'hFFFF, 16'h0001, 1'b1);
        end
        check("release_first", 17'h10001);

        run(16'd1060,  16'd11000, 1'b0); check("dec_1060_11000",  {1'b0, 16'd12060});
        run(16'd12500, 16'd3100,  1'b1); check("dec_12500_3100",  {1'b0, 16'd15601});
        run(16'd30143, 16'd2200,  1'b0); check("dec_30143_2200",  {1'b0, 16'd32343});
        run(16'd1140,  16'd21000, 1'b1); check("dec_1140_21000",  {1'b0, 16'd22141});

        run(16'hAAAA, 16'h5555, 1'b1); check("prop_aaaa_5555", 17'h10000);
        run(16'hFFFF, 16'h0000, 1'b1); check("prop_ffff_0",    17'h10000);
        run(16'hFFFF, 16'hFFFF, 1'b1); check("max_operands",   17'h1FFFF);
        run(16'h0000, 16'h0000, 1'b0); check("zero_operands",  17'h00000);

        run(16'h000F, 16'h0001, 1'b0); check("slice0_boundary", 17'h00010);
        run(16'h0FFF, 16'h0001, 1'b0); check("slice2_boundary", 17'h01000);
        run(16'h8000, 16'h8000, 1'b0); check("msb_carry_out",   17'h10000);

        // Back-to-back vectors with a one-edge reset dropping the in-flight result.
        cycle(16'h1234, 16'h4321, 1'b0, 1'b1);
        cycle(16'hF000, 16'h1000, 1'b1, 1'b1);
        cycle(16'h7777, 16'h1111, 1'b0, 1'b0);
        check("midreset_zero", 17'h00000);
        cycle(16'h0100, 16'h0200, 1'b0, 1'b1);
        check("midreset_release", (LAT == 2) ? 17'h00000 : 17'h00300);
        cycle(16'h0005, 16'h0006, 1'b1, 1'b1);
        check("midreset_next", (LAT == 2) ? 17'h00300 : 17'h0000C);

        for (int i = 0; i < 10000; i++) begin
            cycle(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            check("random", m_out);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
